// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the multi-cycle barrel shift sequencer:
// FSM state encoding, shift-direction codes and default sizes.
package barrel_shift_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SHW   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shift_seq_stage.sv
// One log-stage of the barrel shifter: shifts by 2^k when enabled, else passes data through.
module shift_stage_var
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_k,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data
);

  logic [SHW:0]       w_dist;
  logic [WIDTH-1:0]   w_left;
  logic [WIDTH-1:0]   w_right;
  logic [WIDTH-1:0]   w_fillMask;

  assign w_dist     = (SHW+1)'(1) << i_k;
  assign w_left     = i_data << w_dist;
  // Vacated upper bits on a right shift are exactly the ones cleared in an all-ones vector.
  assign w_fillMask = ~({WIDTH{1'b1}} >> w_dist);
  assign w_right    = (i_data >> w_dist) | (i_fill ? w_fillMask : '0);

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      if (i_dir == DIR_RIGHT) o_data = w_right;
      else                    o_data = w_left;
    end
  end

endmodule

// File: rtl/barrel_shift_seq.sv
// Multi-cycle barrel shift sequencer: captures an operand, applies one log-stage
// per clock, then holds the result until the consumer takes it.
module barrel_shift_seq
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   amt,
  input  logic             dir,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  localparam int K_LAST = SHW - 1;

  state_t           r_state;
  state_t           w_nextState;
  logic [SHW-1:0]   r_k;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_amt;
  logic             r_dir;
  logic             r_fill;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_stage;
  logic             w_lastStage;

  assign w_lastStage = (int'(r_k) == K_LAST);

  shift_stage_var #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_stage (
    .i_data (r_work),
    .i_k    (r_k),
    .i_en   (r_amt[r_k]),
    .i_dir  (r_dir),
    .i_fill (r_fill),
    .o_data (w_stage)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)    w_nextState = S_SHIFT;
      S_SHIFT: if (w_lastStage) w_nextState = S_DONE;
      S_DONE:  if (out_ready)   w_nextState = S_IDLE;
      default:                  w_nextState = S_IDLE;
    endcase
  end

  // Sign fill is resolved at capture so later stages never look at the live inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_work <= '0;
      r_amt  <= '0;
      r_dir  <= 1'b0;
      r_fill <= 1'b0;
      r_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work <= din;
            r_amt  <= amt;
            r_dir  <= dir;
            r_fill <= (dir == DIR_RIGHT) & arith & din[WIDTH-1];
            r_k    <= '0;
          end
        end
        S_SHIFT: begin
          r_work <= w_stage;
          r_k    <= r_k + 1'b1;
          if (w_lastStage) r_dout <= w_stage;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign dout      = r_dout;

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Directed self-checking bench for barrel_shift_seq with hand-computed results.
module tb_barrel_shift_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] amt;
  logic       dir;
  logic       arith;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       busy;

  int total;
  int bad;

  barrel_shift_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .amt       (amt),
    .dir       (dir),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Waits up to a bounded number of edges for out_valid; returns edges seen.
  task automatic waitResult(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] d, input logic [2:0] a,
                               input logic r, input logic ar, input logic [7:0] expDout,
                               input bit consume);
    int cycles;
    checkOutput({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1; din = d; amt = a; dir = r; arith = ar;
    @(posedge clk); #1;
    in_valid = 1'b0;
    din = ~d; amt = ~a; dir = ~r; arith = ~ar;
    checkOutput({tag, "_busy"}, busy, 1);
    @(posedge clk); #1;
    waitResult(cycles);
    checkOutput({tag, "_lat"}, cycles, 3);
    checkOutput({tag, "_dout"}, dout, expDout);
    checkOutput({tag, "_inrdy"}, in_ready, 0);
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({tag, "_ovdrop"}, out_valid, 0);
      checkOutput({tag, "_hold"}, dout, expDout);
    end
  endtask

  initial begin
    int cycles;
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; din = '0; amt = '0; dir = 1'b0; arith = 1'b0; out_ready = 1'b0;
    #2;
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_ov", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_inrdy", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("lsr3", 8'hB6, 3'd3, 1'b1, 1'b0, 8'h16, 1'b1);
    applyStimulus("asr2", 8'hB6, 3'd2, 1'b1, 1'b1, 8'hED, 1'b1);
    applyStimulus("lsl5", 8'h81, 3'd5, 1'b0, 1'b1, 8'h20, 1'b1);
    applyStimulus("amt0", 8'h5A, 3'd0, 1'b1, 1'b0, 8'h5A, 1'b1);
    applyStimulus("lsl7", 8'h03, 3'd7, 1'b0, 1'b0, 8'h80, 1'b1);
    applyStimulus("asr7", 8'h80, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b1);

    // Backpressure: result pending while a new operand is offered.
    applyStimulus("bp", 8'hB6, 3'd3, 1'b1, 1'b0, 8'h16, 1'b0);
    in_valid = 1'b1; din = 8'hFF; amt = 3'd1; dir = 1'b0; arith = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_dout", dout, 8'h16);
      checkOutput("bp_ov", out_valid, 1);
      checkOutput("bp_inrdy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_idle_ov", out_valid, 0);
    checkOutput("bp_idle_inrdy", in_ready, 1);
    checkOutput("bp_idle_dout", dout, 8'h16);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_acc_busy", busy, 1);
    @(posedge clk); #1;
    waitResult(cycles);
    checkOutput("bp_ff_lat", cycles, 3);
    checkOutput("bp_ff_dout", dout, 8'hFE);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the second SHIFT cycle discards the operation.
    in_valid = 1'b1; din = 8'hB6; amt = 3'd3; dir = 1'b1; arith = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_ov", out_valid, 0);
    checkOutput("mid_dout", dout, 0);
    checkOutput("mid_inrdy", in_ready, 1);
    checkOutput("mid_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_stay_ov", out_valid, 0);
    applyStimulus("post", 8'h0F, 3'd4, 1'b0, 1'b0, 8'hF0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrel_shift_seq.md
Name: barrel_shift_seq

Overview:
- Multi-cycle 8-bit barrel shift sequencer. Applies one log-stage per clock: shift by 1, then 2, then 4, each gated by one bit of the shift amount.
- Sits between the operand source and the result consumer, with valid/ready handshakes on both sides.
- Supports logical left, logical right and arithmetic right shifts. Latency is fixed regardless of shift amount.

Parameters:
- WIDTH, 8, data width in bits.
- SHW, 3, shift-amount width; equals log2(WIDTH) and is also the number of SHIFT cycles.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source has an operand.
- in_ready  output  1  block can accept an operand.
- din  input  WIDTH  operand data.
- amt  input  SHW  shift amount, 0..WIDTH-1.
- dir  input  1  0 = left, 1 = right.
- arith  input  1  right shifts only: 1 = fill with sign bit, 0 = fill with zeros. Ignored when dir=0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- dout  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, dout=0, out_valid=0, busy=0, stage counter=0, captured operands=0. in_ready=1 once in IDLE.
- States: IDLE, SHIFT, DONE. Encoding is binary and fixed in the package.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: capture din into the working register; capture amt, dir, arith; clear stage counter k=0; go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge: if captured amt[k]=1, working register is shifted by 2^k; otherwise it holds.
  - Fill bits:
    - Left: 0.
    - Right, arith=0: 0.
    - Right, arith=1: the captured original din[WIDTH-1], replicated.
  - k increments each edge. On the edge where k=SHW-1: load the final value into dout, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; dout holds stable.
  - in_ready=0; in_valid is ignored and the operand is not captured.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - dout keeps its last value after the handshake until the next result is loaded.
- Latency: acceptance at edge E0 gives out_valid=1 after edge E0+SHW (3 for the defaults). This holds for every amt, including 0.
- Throughput: at most one operation per SHW+2 cycles. There is no back-to-back overlap: IDLE must be re-entered first.
- Operand stability: din, amt, dir and arith may change freely after acceptance; only the captured copies are used.
- Reset asserted mid-SHIFT or in DONE: immediate return to reset values. The in-flight operation is discarded with no partial output.
- Width rules:
  - All shifts are confined to WIDTH bits; bits shifted past either end are lost.
  - amt is unsigned; amt=WIDTH-1 is the maximum.
  - Left shift never uses sign fill.

Decomposition:
- Shared package barrel_shift_pkg holds:
  - state localparams S_IDLE=0, S_SHIFT=1, S_DONE=2;
  - DIR_LEFT=0, DIR_RIGHT=1;
  - default WIDTH and SHW.
- One combinational sub-module, shift_stage_var:
  - inputs: data, stage index k, enable (amt[k]), dir, fill bit;
  - output: data shifted by 2^k, or passed through when enable=0.
- The top level holds the FSM, stage counter, captured operand registers and output register.

Test Plan:
- din=8'hB6, amt=3, dir=1, arith=0 -> out_valid rises 3 edges after acceptance, dout=8'h16.
- din=8'hB6, amt=2, dir=1, arith=1 -> dout=8'hED (sign fill).
- din=8'h81, amt=5, dir=0, arith=1 -> dout=8'h20 (arith ignored on left shifts).
- din=8'h5A, amt=0, dir=1 -> dout=8'h5A with the same 3-cycle latency.
- Backpressure: result 8'h16 pending, out_ready held low 4 cycles, in_valid=1 with din=8'hFF meanwhile. Required:
  - dout stays 8'h16, out_valid=1, in_ready=0;
  - after out_ready=1, the block returns to IDLE and the 8'hFF operand is accepted only then.
- Reset mid-op: rst pulsed during the second SHIFT cycle of an operation on 8'hB6. Required:
  - out_valid=0, dout=0, in_ready=1 immediately;
  - a following operation din=8'h0F, amt=4, dir=0 yields dout=8'hF0.
